// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment display path: the segment pattern table
// used by both the display-side bcd decoder and this read-back decoder, the
// digit-enable encodings and the scan decoder FSM states.
package fnd_pkg;

  // Active-low segment patterns, index = code. 0x0-0xD are glyphs,
  // 0xE is the dot-only pattern and 0xF is a blank digit.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h7f, 8'hff
  };

  localparam logic [7:0] SEG_DOT   = 8'h7f;
  localparam logic [7:0] SEG_BLANK = 8'hff;

  localparam logic [3:0] CODE_MAX_DIGIT = 4'hD;
  localparam logic [3:0] CODE_DOT       = 4'hE;
  localparam logic [3:0] CODE_BLANK     = 4'hF;

  // Digit enables are active-low, exactly one position driven low.
  localparam logic [3:0] COM_POS0 = 4'b1110;
  localparam logic [3:0] COM_POS1 = 4'b1101;
  localparam logic [3:0] COM_POS2 = 4'b1011;
  localparam logic [3:0] COM_POS3 = 4'b0111;
  localparam logic [3:0] COM_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PUBLISH = 2'd2
  } fsm_state_e;

  // Returns {hit, code}; hit=0 means the byte is not a known pattern.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Returns {one_hot_low, position}.
  function automatic logic [2:0] com_decode(input logic [3:0] com);
    logic [2:0] r;
    case (com)
      COM_POS0: r = {1'b1, 2'd0};
      COM_POS1: r = {1'b1, 2'd1};
      COM_POS2: r = {1'b1, 2'd2};
      COM_POS3: r = {1'b1, 2'd3};
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fnd_slot_detector.sv
// Synchronizes the multiplexed display bus and emits one strobe per stable
// bus value (a "slot"), together with the decoded position and pattern code.
module fnd_slot_detector
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fnd_com_i,
  input  logic [7:0] fnd_data_i,
  output logic       slot_o,
  output logic [1:0] pos_o,
  output logic       com_ok_o,
  output logic [3:0] code_o,
  output logic       illegal_o
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;

  logic [11:0]   sync1_q, sync2_q, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          slot_q, slot_d;
  logic          changed;
  logic [4:0]    seg_res;
  logic [2:0]    com_res;

  // Two-flop synchronizer on the whole 12-bit bus; idle (all high) at reset
  // so an undriven panel does not look like a bus change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {fnd_com_i, fnd_data_i};
      sync2_q <= sync1_q;
    end
  end

  // Settle counter: restart on any change, strobe once when it saturates.
  always_comb begin
    changed = (sync2_q != last_q);
    cnt_d   = cnt_q;
    slot_d  = 1'b0;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(SETTLE_CYCLES - 1)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(SETTLE_CYCLES - 2)) slot_d = 1'b1;
    end
  end

  // Settle state registers; last_q is the value the counter is timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '1;
      cnt_q  <= '0;
      slot_q <= 1'b0;
    end else begin
      last_q <= sync2_q;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  // Decode the settled value; last_q is unchanged while slot_q is high.
  always_comb begin
    com_res   = com_decode(last_q[11:8]);
    seg_res   = seg_decode(last_q[7:0]);
    pos_o     = com_res[1:0];
    com_ok_o  = com_res[2];
    code_o    = seg_res[3:0];
    illegal_o = ~seg_res[4];
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the four displayed digits and dot flags from the scanned display
// bus and hands each complete 8-slot frame to a consumer.
//
// Handshake: o_valid/i_ready. A frame transfers on a clock edge where
// o_valid && i_ready; o_digits/o_dots are stable while o_valid is high and
// o_valid never drops without a transfer (except on rst).
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dots,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_locked,
  output logic        o_overrun,
  output logic [7:0]  o_err_cnt,
  input  logic        i_clr,
  output fsm_state_e  o_dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;

  logic       slot, com_ok, illegal;
  logic [1:0] pos;
  logic [3:0] code;

  fnd_slot_detector #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .fnd_com_i (fnd_com),
    .fnd_data_i(fnd_data),
    .slot_o    (slot),
    .pos_o     (pos),
    .com_ok_o  (com_ok),
    .code_o    (code),
    .illegal_o (illegal)
  );

  fsm_state_e    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   work_dig_q, work_dig_d;
  logic [3:0]    work_dot_q, work_dot_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   out_dig_q, out_dig_d;
  logic [3:0]    out_dot_q, out_dot_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    err_q, err_d;

  logic          slot_ok, err_inc, publish;
  logic [15:0]   slot_dig;
  logic [3:0]    slot_dot;

  // Working registers with the current slot applied; a frame started from
  // SYNC builds on cleared registers so partial frames never leak through.
  always_comb begin
    slot_ok  = com_ok && !illegal;
    slot_dig = (state_q == ST_SYNC) ? 16'h0000 : work_dig_q;
    slot_dot = (state_q == ST_SYNC) ? 4'h0 : work_dot_q;
    if (code <= CODE_MAX_DIGIT) begin
      slot_dig[{pos, 2'b00} +: 4] = code;
    end else if (code == CODE_DOT) begin
      slot_dot[pos] = 1'b1;
    end
  end

  // Scan alignment FSM: next state, slot index, working frame, timeout.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    work_dig_d = work_dig_q;
    work_dot_d = work_dot_q;
    tmo_d      = '0;
    err_inc    = 1'b0;
    publish    = 1'b0;
    case (state_q)
      ST_SYNC: begin
        // Only a clean position-0 slot starts a frame; anything else is
        // just scan traffic we are not aligned to yet.
        if (slot && slot_ok && (pos == 2'd0)) begin
          work_dig_d = slot_dig;
          work_dot_d = slot_dot;
          idx_d      = 3'd1;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (slot) begin
          if (!slot_ok || (pos != idx_q[1:0])) begin
            err_inc = 1'b1;
            idx_d   = 3'd0;
            state_d = ST_SYNC;
          end else begin
            work_dig_d = slot_dig;
            work_dot_d = slot_dot;
            if (idx_q == 3'd7) begin
              idx_d   = 3'd0;
              state_d = ST_PUBLISH;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          idx_d   = 3'd0;
          state_d = ST_SYNC;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_PUBLISH: begin
        publish    = 1'b1;
        work_dig_d = '0;
        work_dot_d = '0;
        idx_d      = 3'd0;
        state_d    = ST_CAPTURE;
      end
      default: begin
        idx_d   = 3'd0;
        state_d = ST_SYNC;
      end
    endcase
  end

  // Output holding register, overrun flag and error counter; i_clr wins
  // over a same-cycle error or overrun.
  always_comb begin
    out_dig_d = out_dig_q;
    out_dot_d = out_dot_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (publish) begin
      if (valid_q && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_dig_d = work_dig_q;
        out_dot_d = work_dot_q;
        valid_d   = 1'b1;
      end
    end
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (i_clr) begin
      overrun_d = 1'b0;
      err_d     = 8'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      idx_q      <= '0;
      work_dig_q <= '0;
      work_dot_q <= '0;
      tmo_q      <= '0;
      out_dig_q  <= '0;
      out_dot_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      work_dig_q <= work_dig_d;
      work_dot_q <= work_dot_d;
      tmo_q      <= tmo_d;
      out_dig_q  <= out_dig_d;
      out_dot_q  <= out_dot_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  assign o_digits    = out_dig_q;
  assign o_dots      = out_dot_q;
  assign o_valid     = valid_q;
  assign o_locked    = (state_q != ST_SYNC);
  assign o_overrun   = overrun_q;
  assign o_err_cnt   = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: drives scan frames on the display bus
// and checks captured frames, lock, overrun, error count and reset.
module tb_fnd_scan_decoder;
  import fnd_pkg::*;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int HOLD    = 24;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fnd_com = 4'hF;
  logic [7:0]  fnd_data = 8'hFF;
  logic        i_ready = 1'b0;
  logic        i_clr = 1'b0;
  logic [15:0] o_digits;
  logic [3:0]  o_dots;
  logic        o_valid, o_locked, o_overrun;
  logic [7:0]  o_err_cnt;
  fsm_state_e  dbg_state;

  always #5 clk = ~clk;

  fnd_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data),
    .o_digits   (o_digits),
    .o_dots     (o_dots),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_locked   (o_locked),
    .o_overrun  (o_overrun),
    .o_err_cnt  (o_err_cnt),
    .i_clr      (i_clr),
    .o_dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {dots, digits} of a frame the consumer should receive.
  logic [19:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("frame", {12'd0, o_dots, o_digits}, {12'd0, exp_q.pop_front()});
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [3:0] com_of(input int pos);
    case (pos)
      0: com_of = COM_POS0;
      1: com_of = COM_POS1;
      2: com_of = COM_POS2;
      default: com_of = COM_POS3;
    endcase
  endfunction

  task automatic drive_bus(input logic [3:0] com, input logic [7:0] data, input int cycles);
    fnd_com  = com;
    fnd_data = data;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_slot(input int pos, input logic [7:0] data);
    drive_bus(com_of(pos), data, HOLD);
  endtask

  // Frame bytes packed MSB first: slot 0 in [63:56] ... slot 7 in [7:0].
  task automatic send_frame(input logic [63:0] f, input int first);
    for (int i = first; i < 8; i++) send_slot(i % 4, f[63-8*i -: 8]);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] FRM_A = 64'hb09992f9_ffff7fff; // 3,4,5,1 dot@2
  localparam logic [63:0] FRM_B = 64'hc0f9a4b0_7f80ff7f; // 0,8,2,3 dots 1001
  localparam logic [63:0] FRM_C = 64'ha1c68388_ffffffff; // D,C,B,A
  localparam logic [63:0] FRM_D = 64'h9082f899_ff7f7fff; // 9,6,7,4 dots 0110
  localparam logic [63:0] FRM_E = 64'h9288c6a1_7fffff7f; // 5,A,C,D dots 1001
  localparam logic [63:0] FRM_F = 64'hc0c0c0c0_ffffffff; // 0,0,0,0
  localparam logic [63:0] FRM_G = 64'hf9a4b099_ffffff7f; // 1,2,3,4 dots 1000

  // Hard stop so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    idle(3);
    @(negedge clk);
    check("rst_digits", 32'(o_digits), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_locked", 32'(o_locked), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_SYNC));
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- 1: basic frame ----
    idle(5);
    send_frame(FRM_A, 0);
    @(negedge clk);
    check("t1_valid", 32'(o_valid), 32'h1);
    check("t1_digits", 32'(o_digits), 32'h1543);
    check("t1_dots", 32'(o_dots), 32'b0100);
    check("t1_locked", 32'(o_locked), 32'h1);
    exp_q.push_back({4'b0100, 16'h1543});
    @(posedge clk); #1;
    i_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("t1_valid_drop", 32'(o_valid), 32'h0);

    // ---- 2: overrun ----
    @(posedge clk); #1;
    i_ready = 1'b0;
    send_frame(FRM_B, 0);
    @(negedge clk);
    check("t2_valid", 32'(o_valid), 32'h1);
    send_frame(FRM_C, 0);
    @(negedge clk);
    check("t2_overrun", 32'(o_overrun), 32'h1);
    check("t2_err", 32'(o_err_cnt), 32'h0);
    check("t2_held_digits", 32'(o_digits), 32'h3280);
    check("t2_held_dots", 32'(o_dots), 32'b1001);
    @(posedge clk); #1;
    i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    @(negedge clk);
    check("t2_clr_overrun", 32'(o_overrun), 32'h0);
    exp_q.push_back({4'b1001, 16'h3280});
    @(posedge clk); #1;
    i_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("t2_valid_drop", 32'(o_valid), 32'h0);

    // ---- 3: protocol errors ----
    @(posedge clk); #1;
    send_slot(0, 8'hc0);
    send_slot(1, 8'hf9);
    drive_bus(4'b1010, 8'hc0, HOLD);
    @(negedge clk);
    check("t3_err1", 32'(o_err_cnt), 32'd1);
    check("t3_unlock1", 32'(o_locked), 32'h0);
    @(posedge clk); #1;
    send_slot(0, 8'ha4);
    send_slot(1, 8'hb0);
    send_slot(2, 8'h00);
    @(negedge clk);
    check("t3_err2", 32'(o_err_cnt), 32'd2);
    check("t3_unlock2", 32'(o_locked), 32'h0);
    check("t3_no_valid", 32'(o_valid), 32'h0);
    @(posedge clk); #1;
    exp_q.push_back({4'b0110, 16'h4769});
    send_slot(0, FRM_D[63:56]);
    @(negedge clk);
    check("t3_relock", 32'(o_locked), 32'h1);
    @(posedge clk); #1;
    send_frame(FRM_D, 1);
    idle(3);
    @(negedge clk);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // ---- 4: short glitch between slots ----
    @(posedge clk); #1;
    exp_q.push_back({4'b1001, 16'hDCA5});
    send_slot(0, FRM_E[63:56]);
    drive_bus(COM_POS3, 8'h80, SETTLE - 2);
    send_frame(FRM_E, 1);
    idle(3);
    @(negedge clk);
    check("t4_err", 32'(o_err_cnt), 32'd2);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    check("t4_digits", 32'(o_digits), 32'hDCA5);

    // ---- 5: timeout ----
    @(posedge clk); #1;
    send_slot(0, 8'hc0);
    send_slot(1, 8'hf9);
    @(negedge clk);
    check("t5_locked", 32'(o_locked), 32'h1);
    @(posedge clk); #1;
    idle(TIMEOUT + 40);
    @(negedge clk);
    check("t5_unlocked", 32'(o_locked), 32'h0);
    check("t5_err", 32'(o_err_cnt), 32'd2);

    // ---- 6: reset mid-frame with a pending frame ----
    @(posedge clk); #1;
    i_ready = 1'b0;
    send_frame(FRM_F, 0);
    @(negedge clk);
    check("t6_valid", 32'(o_valid), 32'h1);
    @(posedge clk); #1;
    send_slot(0, 8'ha4);
    send_slot(1, 8'hb0);
    rst      = 1'b1;
    fnd_com  = COM_IDLE;
    fnd_data = SEG_BLANK;
    @(negedge clk);
    check("t6_rst_valid", 32'(o_valid), 32'h0);
    check("t6_rst_locked", 32'(o_locked), 32'h0);
    check("t6_rst_err", 32'(o_err_cnt), 32'h0);
    check("t6_rst_out", {12'd0, o_dots, o_digits}, 32'h0);
    idle(3);
    rst     = 1'b0;
    i_ready = 1'b1;
    idle(5);
    exp_q.push_back({4'b1000, 16'h4321});
    send_frame(FRM_G, 0);
    idle(3);
    @(negedge clk);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check("t6_digits", 32'(o_digits), 32'h4321);
    check("t6_locked", 32'(o_locked), 32'h1);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
